// File: rtl/tt_um_ram8_macro.sv
// tt_um_ram8_macro: 32 x 8 flip-flop RAM with a registered, read-first output.
// ui_in[4:0] selects the word, ui_in[5] is the write enable and uio_in is the
// write data. The bidirectional pins are always inputs. A synchronous
// active-low reset clears every word and the output register.

module tt_um_ram8_macro (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int DEPTH = 32;
    localparam int WIDTH = 8;
    localparam int AW    = 5;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data;
    logic [AW-1:0]    addr;
    logic             wr_en;
    logic             unused_reserved;

    assign addr  = ui_in[AW-1:0];
    assign wr_en = ui_in[5];

    // ui_in[7:6] are reserved pins. They do not affect any state or output.
    assign unused_reserved = &{1'b0, ui_in[7:6]};

    // The bidirectional pins are inputs only, so both outputs are constant zero.
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
    assign uo_out  = rd_data;

    // Reset clears all state. Otherwise, when enabled, do a read-first access:
    // capture the old word, then write the new data into that word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else if (ena) begin
            rd_data <= mem[addr];
            if (wr_en) begin
                mem[addr] <= uio_in;
            end
        end
    end

endmodule

// File: tb/tb_tt_um_ram8_macro.sv
// Testbench for tt_um_ram8_macro. A behavioural model predicts uo_out for each
// driven cycle. The prediction is queued when stimulus is applied and compared
// when the registered output appears after the clock edge.

module tb_tt_um_ram8_macro;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic [7:0] model_mem [32];
    logic [7:0] model_out;
    logic [7:0] exp_q [$];

    int check_count;
    int pass_count;

    tt_um_ram8_macro dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Free-running clock with a 10-time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the values differ.
    task automatic checkOutput(input string tag, input logic [7:0] actual,
                               input logic [7:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle on the falling edge and queue the model's prediction.
    // After the rising edge, pop the prediction and compare it with the outputs.
    task automatic applyStimulus(input string tag, input logic r, input logic e,
                                 input logic we, input logic [4:0] a,
                                 input logic [7:0] d, input logic [1:0] rsv);
        logic [7:0] exp_val;
        @(negedge clk);
        rst_n  = r;
        ena    = e;
        ui_in  = {rsv, we, a};
        uio_in = d;
        if (!r) begin
            for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
            model_out = 8'h00;
        end else if (e) begin
            model_out = model_mem[a];
            if (we) model_mem[a] = d;
        end
        exp_q.push_back(model_out);
        @(posedge clk);
        #1;
        exp_val = exp_q.pop_front();
        checkOutput(tag, uo_out, exp_val);
        checkOutput("uio_oe", uio_oe, 8'h00);
        checkOutput("uio_out", uio_out, 8'h00);
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        model_out   = 8'h00;
        for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset for 5 cycles, mixing ena and write requests that must be ignored.
        for (int i = 0; i < 5; i++) begin
            applyStimulus("reset", 1'b0, i[0], 1'b1, 5'(i), 8'hC3, 2'b00);
        end

        // After reset, every word must read back as zero.
        for (int i = 0; i < 32; i++) begin
            applyStimulus("reset_read", 1'b1, 1'b1, 1'b0, 5'(i), 8'h00, 2'b00);
            checkOutput("reset_zero", uo_out, 8'h00);
        end

        // Write two words, then read each one back.
        applyStimulus("wr3", 1'b1, 1'b1, 1'b1, 5'd3, 8'hA5, 2'b00);
        applyStimulus("wr31", 1'b1, 1'b1, 1'b1, 5'd31, 8'h5A, 2'b00);
        applyStimulus("rd3", 1'b1, 1'b1, 1'b0, 5'd3, 8'h00, 2'b00);
        checkOutput("rd3_a5", uo_out, 8'hA5);
        applyStimulus("rd31", 1'b1, 1'b1, 1'b0, 5'd31, 8'h00, 2'b00);
        checkOutput("rd31_5a", uo_out, 8'h5A);

        // Read-during-write returns the old word; the new word appears on the next read.
        applyStimulus("wr7", 1'b1, 1'b1, 1'b1, 5'd7, 8'h11, 2'b00);
        applyStimulus("rdw7", 1'b1, 1'b1, 1'b1, 5'd7, 8'h22, 2'b00);
        checkOutput("read_first_old", uo_out, 8'h11);
        applyStimulus("rd7", 1'b1, 1'b1, 1'b0, 5'd7, 8'h00, 2'b00);
        checkOutput("read_first_new", uo_out, 8'h22);

        // With ena low, writes are blocked and the output holds its last value.
        for (int i = 0; i < 3; i++) begin
            applyStimulus("ena_off", 1'b1, 1'b0, 1'b1, 5'd4, 8'hFF, 2'b00);
            checkOutput("ena_hold", uo_out, 8'h22);
        end
        applyStimulus("rd4", 1'b1, 1'b1, 1'b0, 5'd4, 8'h00, 2'b00);
        checkOutput("ena_nowrite", uo_out, 8'h00);

        // Write every word back-to-back, then read all of them,
        // with random values on the reserved bits.
        for (int i = 0; i < 32; i++) begin
            applyStimulus("sweep_wr", 1'b1, 1'b1, 1'b1, 5'(i), 8'(i) ^ 8'h3C,
                          2'($urandom_range(3)));
        end
        for (int i = 0; i < 32; i++) begin
            applyStimulus("sweep_rd", 1'b1, 1'b1, 1'b0, 5'(i), 8'h00,
                          2'($urandom_range(3)));
            checkOutput("sweep_val", uo_out, 8'(i) ^ 8'h3C);
        end

        // A reset in mid-run discards the concurrent write and all stored data.
        applyStimulus("mid_reset", 1'b0, 1'b1, 1'b1, 5'd9, 8'h77, 2'b00);
        applyStimulus("rd9", 1'b1, 1'b1, 1'b0, 5'd9, 8'h00, 2'b00);
        checkOutput("mid_reset_rd9", uo_out, 8'h00);
        applyStimulus("rd31b", 1'b1, 1'b1, 1'b0, 5'd31, 8'h00, 2'b00);
        checkOutput("mid_reset_rd31", uo_out, 8'h00);

        // Normal operation resumes immediately after the reset.
        applyStimulus("post_wr", 1'b1, 1'b1, 1'b1, 5'd9, 8'h96, 2'b10);
        applyStimulus("post_rd", 1'b1, 1'b1, 1'b0, 5'd9, 8'h00, 2'b01);
        checkOutput("post_reset_rd9", uo_out, 8'h96);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/tt_um_ram8_macro.md
TT_UM_RAM8_MACRO -- requirements
Module: tt_um_ram8_macro

Interface
REQ-001 Parameter: none externally settable; fixed localparams DEPTH=32 (words), WIDTH=8 (bits/word), AW=5 (address bits).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 ena  input  1  design-selected enable; 1 = block operates, 0 = block idle.
REQ-005 ui_in  input  8  control and address:
  - [4:0] word address.
  - [5] write enable (WE).
  - [7:6] reserved, ignored.
REQ-006 uio_in  input  8  write data.
REQ-007 uo_out  output  8  registered read data.
REQ-008 uio_out  output  8  unused; tied to 8'h00.
REQ-009 uio_oe  output  8  tied to 8'h00, so all bidirectional pins are inputs.
REQ-010 Gate-level builds add VPWR/VGND power ports; RTL has none.

Function
REQ-011 Storage SHALL be 32 words x 8 bits, implemented in flip-flops/latches; no hard macro.
REQ-012 Write: at a rising clk with rst_n=1, ena=1 and ui_in[5]=1, mem[ui_in[4:0]] SHALL be loaded with uio_in.
REQ-013 Read: at every rising clk with rst_n=1 and ena=1, uo_out SHALL be loaded with mem[ui_in[4:0]].
  - Read latency is 1 cycle: the address is sampled at edge N and the data is visible after edge N.
REQ-014 Read-during-write to the same address SHALL be read-first.
  - uo_out gets the pre-write contents.
  - The new value is visible on the next read cycle.
REQ-015 With ena=0, no word SHALL be written and uo_out SHALL hold its last value, regardless of WE, address or data.
REQ-016 ui_in[7:6] SHALL have no effect on any state or output.
REQ-017 Addressing covers the full 5-bit range 0..31. There is no out-of-range condition and no wrap logic.
REQ-018 Back-to-back writes on consecutive cycles to any addresses SHALL all take effect; there are no wait states.
REQ-019 uio_out and uio_oe SHALL be constant 8'h00 in all states, including during reset.

Reset
REQ-020 At a rising clk with rst_n=0, all 32 words SHALL be cleared to 8'h00 and uo_out SHALL become 8'h00, independent of ena.
REQ-021 Reset SHALL take priority over any simultaneous write or read; a write requested in a reset cycle is discarded.
REQ-022 Asserting reset mid-operation SHALL discard all stored data.
  - The first cycle after rst_n returns to 1 behaves as normal operation on cleared memory.
REQ-023 Outputs are undefined before the first reset edge; the bench SHALL apply reset for at least 2 cycles before checking.

Verification
REQ-024 Reset: hold rst_n=0 for 5 cycles, then read addresses 0..31 with ena=1, WE=0.
  - Required: uo_out=8'h00 for every address, and uio_oe=8'h00 throughout.
REQ-025 Write/read: write 8'hA5 to address 3 and 8'h5A to address 31, then read address 3 and then address 31.
  - Required: uo_out=8'hA5 one cycle after address 3 is presented, then 8'h5A.
REQ-026 Read-first: mem[7]=8'h11, then one cycle with address 7, WE=1, uio_in=8'h22.
  - Required: uo_out=8'h11 after that edge and 8'h22 after the next read of address 7.
REQ-027 Enable gating: with ena=0, drive address 4, WE=1, uio_in=8'hFF for 3 cycles, then read address 4 with ena=1.
  - Required: uo_out unchanged during the ena=0 cycles, then 8'h00.
REQ-028 Full sweep: write the value addr^8'h3C to every address 0..31 on back-to-back cycles, then read all 32 addresses.
  - Required: every readback matches, and ui_in[7:6] toggling randomly has no effect.
REQ-029 Mid-run reset: after the sweep, apply one rst_n=0 cycle concurrent with a write of 8'h77 to address 9, then read address 9.
  - Required: uo_out=8'h00.
